noc_control_center: RTL and testbench
=====================================

# noc_control_center

Clocked, parametrised run controller for the CNN NoC. It accepts one start token and broadcasts a go token to up to `NCH` client channels (PEs, adder, memory). It collects one finish token per enabled channel, repeats this for a programmable number of passes, then issues one done token. Compared with the fixed single-pass, eleven-channel controller it replaces, it adds:
- a per-run channel-enable mask,
- multi-pass sequencing,
- early-finish overlap (a channel may finish while others are still being started),
- a watchdog timeout with an error flag.

## Interface
Parameters:
- `NCH`, 11, number of client channels (9 PEs + adder + memory).
- `PW`, 8, width of pass count and pass index.
- `TO_W`, 16, watchdog counter width.
- `TIMEOUT`, 1000, cycles allowed per pass; 0 disables the watchdog. Must be less than 2^TO_W.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  run request.
- `start_ready`  out  1  controller can accept a run.
- `pass_count`  in  PW  passes for this run, sampled on start handshake; 0 is treated as 1.
- `chan_en`  in  NCH  channel-enable mask, sampled on start handshake.
- `go_valid`  out  NCH  per-channel go token.
- `go_ready`  in  NCH  per-channel go accept.
- `fin_valid`  in  NCH  per-channel finish token.
- `fin_ready`  out  NCH  per-channel finish accept.
- `done_valid`  out  1  run complete.
- `done_ready`  in  1  done accept.
- `busy`  out  1  high in every state except IDLE.
- `err_timeout`  out  1  watchdog fired during the current or last run.
- `pass_idx`  out  PW  index of the current pass, 0-based.

## Operation
- All handshakes are valid/ready. A transfer occurs on any rising edge where both are high.
- States: IDLE, RUN, DONE.
- IDLE:
  - `start_ready`=1 (0 while `rst` is high).
  - On start transfer: latch `chan_en` → `mask` and max(`pass_count`,1) → `npass`; clear `err_timeout`; set `pass_idx`=0.
  - If `chan_en`=0, go to DONE. Otherwise load `pend_go`=`mask`, `pend_fin`=`mask`, clear the timer, and go to RUN.
- RUN:
  - `go_valid` = `pend_go`. Bit i clears on a go transfer on channel i. Transfers complete in any order, several per cycle.
  - `fin_ready[i]` = `pend_fin[i]` & ~`pend_go[i]`: a finish is accepted only after that channel's go. Bit i of `pend_fin` clears on a finish transfer.
  - `fin_valid[i]` while `fin_ready[i]`=0 is not consumed. The sender must hold it.
  - When `pend_go`=0 and `pend_fin`=0 at an edge:
    - if `pass_idx`+1 = `npass`, go to DONE;
    - otherwise increment `pass_idx`, reload `pend_go`/`pend_fin` from `mask`, clear the timer, and stay in RUN.
  - Watchdog: the timer increments every RUN cycle. If `TIMEOUT`≠0 and the timer reaches `TIMEOUT`-1 with any pending bit still set:
    - set `err_timeout`, clear `pend_go`/`pend_fin`, go to DONE;
    - late finish tokens are then ignored (`fin_ready`=0).
  - Pass completion and watchdog expiry in the same cycle: completion wins and `err_timeout` stays 0.
- DONE: `done_valid`=1 until the done transfer, then IDLE. `err_timeout` holds until the next start transfer.
- `rst` at any time: immediately return to IDLE, drop every valid/ready, abandon in-flight tokens.

## Timing
- Reset values:
  - state IDLE
  - `go_valid`=0, `fin_ready`=0, `done_valid`=0, `busy`=0, `err_timeout`=0, `pass_idx`=0
  - `start_ready`=0 while `rst`=1, 1 from the first cycle after deassertion.
- Start transfer at edge N → `go_valid`=`mask` and `busy`=1 during cycle N+1.
- Zero mask: start at edge N → `done_valid`=1 during cycle N+1.
- A go transfer on channel i at edge K → `go_valid[i]`=0 and `fin_ready[i]`=1 during cycle K+1. A finish can therefore transfer at edge K+1 at the earliest.
- Last finish of a non-final pass at edge M → `go_valid`=`mask` again and `pass_idx` incremented during cycle M+1. There are no bubble cycles beyond this one.
- Last finish of the final pass at edge M → `done_valid` during cycle M+1.
- Done transfer at edge D → `start_ready`=1 during cycle D+1.
- All outputs are functions of registered state only (plus `rst` for `start_ready`). There are no combinational input-to-output paths.

## Test plan
- Run with `NCH`=11, `chan_en`=0x7FF, `pass_count`=1, all go/fin ready immediately:
  - all 11 `go_valid` high at cycle 1 after start;
  - `fin_ready` high at cycle 2;
  - finishes at edge 2 → `done_valid` at cycle 3;
  - `err_timeout`=0.
- `pass_count`=3, `chan_en`=0x005, channel 2 finishes 5 cycles after channel 0:
  - `pass_idx` steps 0→1→2;
  - exactly 3 go and 3 fin transfers per enabled channel;
  - no tokens on channels 1 or 3–10.
- Staggered `go_ready` (channel 0 accepts 10 cycles late) while channel 1 finishes early:
  - channel 1 finish accepted before channel 0's go;
  - pass still ends only after channel 0 finishes.
- `TIMEOUT`=20, channel 4 never asserts `fin_valid`:
  - `err_timeout`=1 and `done_valid`=1 at cycle 21 after pass start;
  - a later `fin_valid[4]` is not accepted;
  - next start clears `err_timeout`.
- `chan_en`=0 and `pass_count`=0:
  - done at cycle 1 after start, no go tokens.
- Assert `rst` mid-pass with `go_valid` partly outstanding:
  - all outputs at reset values immediately;
  - a fresh run afterwards completes normally.

Source files
------------

// File: rtl/noc_control_center.sv
// Run controller for the CNN NoC: broadcasts go tokens to enabled channels, collects
// their finish tokens over a programmable number of passes, then issues one done token.
module noc_control_center #(
  parameter int NCH     = 11,
  parameter int PW      = 8,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [PW-1:0]  pass_count,
  input  logic [NCH-1:0] chan_en,
  output logic [NCH-1:0] go_valid,
  input  logic [NCH-1:0] go_ready,
  input  logic [NCH-1:0] fin_valid,
  output logic [NCH-1:0] fin_ready,
  output logic           done_valid,
  input  logic           done_ready,
  output logic           busy,
  output logic           err_timeout,
  output logic [PW-1:0]  pass_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_e          state_q;
  logic [NCH-1:0]  mask_q;
  logic [NCH-1:0]  pend_go_q;
  logic [NCH-1:0]  pend_fin_q;
  logic [PW-1:0]   npass_q;
  logic [PW-1:0]   pass_idx_q;
  logic [TO_W-1:0] timer_q;
  logic            err_q;

  logic [NCH-1:0]  go_xfer;
  logic [NCH-1:0]  fin_xfer;
  logic [NCH-1:0]  pend_go_d;
  logic [NCH-1:0]  pend_fin_d;
  logic [PW:0]     idx_inc;
  logic            last_pass;
  logic            to_hit;
  logic            pass_clear;

  // A channel may only finish once its go has been accepted.
  assign go_valid    = (state_q == RUN) ? pend_go_q : '0;
  assign fin_ready   = (state_q == RUN) ? (pend_fin_q & ~pend_go_q) : '0;
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign start_ready = (state_q == IDLE) && !rst;
  assign err_timeout = err_q;
  assign pass_idx    = pass_idx_q;

  always_comb begin
    go_xfer    = go_valid & go_ready;
    fin_xfer   = fin_valid & fin_ready;
    pend_go_d  = pend_go_q & ~go_xfer;
    pend_fin_d = pend_fin_q & ~fin_xfer;
    idx_inc    = {1'b0, pass_idx_q} + {{PW{1'b0}}, 1'b1};
    last_pass  = (idx_inc == {1'b0, npass_q});
    pass_clear = (pend_go_d == '0) && (pend_fin_d == '0);
    to_hit     = TO_EN && (timer_q == TO_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      pend_go_q  <= '0;
      pend_fin_q <= '0;
      npass_q    <= PW'(1);
      pass_idx_q <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            mask_q     <= chan_en;
            npass_q    <= (pass_count == '0) ? PW'(1) : pass_count;
            err_q      <= 1'b0;
            pass_idx_q <= '0;
            timer_q    <= '0;
            if (chan_en == '0) begin
              state_q <= DONE;
            end else begin
              pend_go_q  <= chan_en;
              pend_fin_q <= chan_en;
              state_q    <= RUN;
            end
          end
        end
        RUN: begin
          pend_go_q  <= pend_go_d;
          pend_fin_q <= pend_fin_d;
          timer_q    <= timer_q + TO_W'(1);
          // Pass completion takes priority over a watchdog expiry in the same cycle.
          if (pass_clear) begin
            if (last_pass) begin
              state_q <= DONE;
            end else begin
              pass_idx_q <= pass_idx_q + PW'(1);
              pend_go_q  <= mask_q;
              pend_fin_q <= mask_q;
              timer_q    <= '0;
            end
          end else if (to_hit) begin
            err_q      <= 1'b1;
            pend_go_q  <= '0;
            pend_fin_q <= '0;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (done_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_control_center.sv
// Self-checking bench for noc_control_center: a vector table for single-pass and
// zero-mask runs plus hand-written multi-pass, stagger, watchdog and reset sequences.
module tb_noc_control_center;

  localparam int NCH     = 11;
  localparam int PW      = 8;
  localparam int TO_W    = 16;
  localparam int TIMEOUT = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_valid;
  logic           start_ready;
  logic [PW-1:0]  pass_count;
  logic [NCH-1:0] chan_en;
  logic [NCH-1:0] go_valid;
  logic [NCH-1:0] go_ready;
  logic [NCH-1:0] fin_valid;
  logic [NCH-1:0] fin_ready;
  logic           done_valid;
  logic           done_ready;
  logic           busy;
  logic           err_timeout;
  logic [PW-1:0]  pass_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_control_center #(
    .NCH(NCH), .PW(PW), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .pass_count(pass_count), .chan_en(chan_en),
    .go_valid(go_valid), .go_ready(go_ready),
    .fin_valid(fin_valid), .fin_ready(fin_ready),
    .done_valid(done_valid), .done_ready(done_ready),
    .busy(busy), .err_timeout(err_timeout), .pass_idx(pass_idx)
  );

  // One record per cycle: inputs driven during the cycle, outputs expected during it.
  typedef struct packed {
    logic           sv;
    logic [PW-1:0]  pc;
    logic [NCH-1:0] en;
    logic [NCH-1:0] gr;
    logic [NCH-1:0] fv;
    logic           dr;
    logic           sr;
    logic [NCH-1:0] gv;
    logic [NCH-1:0] fr;
    logic           dv;
    logic           bz;
    logic           er;
    logic [PW-1:0]  pi;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start_valid = v.sv;
    pass_count  = v.pc;
    chan_en     = v.en;
    go_ready    = v.gr;
    fin_valid   = v.fv;
    done_ready  = v.dr;
  endtask

  task automatic clearInputs();
    start_valid = 1'b0;
    pass_count  = '0;
    chan_en     = '0;
    go_ready    = '0;
    fin_valid   = '0;
    done_ready  = 1'b0;
  endtask

  // Performs the start handshake; returns just after the edge that accepts it.
  task automatic startRun(input logic [NCH-1:0] en, input logic [PW-1:0] pc);
    @(negedge clk);
    clearInputs();
    start_valid = 1'b1;
    chan_en     = en;
    pass_count  = pc;
    #1;
    checkOutput("start_ready_idle", start_ready, 1);
    @(posedge clk);
  endtask

  task automatic finishDone();
    @(negedge clk);
    clearInputs();
    done_ready = 1'b1;
    #1;
    checkOutput("done_before_accept", done_valid, 1);
    @(negedge clk);
    done_ready = 1'b0;
    #1;
    checkOutput("idle_after_done", start_ready, 1);
  endtask

  initial begin
    logic [NCH-1:0] gx, fx, other;
    int gcnt[NCH];
    int fcnt[NCH];
    int since0, steps, doneAt, fin1, go0, fin0;
    logic [PW-1:0] prevIdx;
    logic doneSeen, errEarly;
    logic [NCH-1:0] expGo[5];
    logic [NCH-1:0] expFr[5];
    logic [PW-1:0]  expIdx[5];
    logic           expDone[5];

    vecs[0] = '{1'b1, 8'd1, 11'h7FF, 11'h7FF, 11'h7FF, 1'b0, 1'b1, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 8'd0, 11'h000, 11'h7FF, 11'h7FF, 1'b0, 1'b0, 11'h7FF, 11'h000, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 8'd0, 11'h000, 11'h7FF, 11'h7FF, 1'b0, 1'b0, 11'h000, 11'h7FF, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 8'd0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b0, 11'h000, 11'h000, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[4] = '{1'b0, 8'd0, 11'h000, 11'h000, 11'h000, 1'b0, 1'b1, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5] = '{1'b1, 8'd0, 11'h000, 11'h7FF, 11'h7FF, 1'b0, 1'b1, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[6] = '{1'b0, 8'd0, 11'h000, 11'h7FF, 11'h7FF, 1'b0, 1'b0, 11'h000, 11'h000, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[7] = '{1'b0, 8'd0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b0, 11'h000, 11'h000, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[8] = '{1'b0, 8'd0, 11'h000, 11'h000, 11'h000, 1'b0, 1'b1, 11'h000, 11'h000, 1'b0, 1'b0, 1'b0, 8'd0};

    rst = 1'b1;
    clearInputs();
    #1;
    checkOutput("rst_start_ready", start_ready, 0);
    checkOutput("rst_go_valid", go_valid, 0);
    checkOutput("rst_fin_ready", fin_ready, 0);
    checkOutput("rst_done_valid", done_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_timeout, 0);
    checkOutput("rst_pass_idx", pass_idx, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] vector table: single pass full mask, zero mask");
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_start_ready", i), start_ready, vecs[i].sr);
      checkOutput($sformatf("v%0d_go_valid", i), go_valid, vecs[i].gv);
      checkOutput($sformatf("v%0d_fin_ready", i), fin_ready, vecs[i].fr);
      checkOutput($sformatf("v%0d_done_valid", i), done_valid, vecs[i].dv);
      checkOutput($sformatf("v%0d_busy", i), busy, vecs[i].bz);
      checkOutput($sformatf("v%0d_err", i), err_timeout, vecs[i].er);
      checkOutput($sformatf("v%0d_pass_idx", i), pass_idx, vecs[i].pi);
    end

    $display("[TB] multi-pass run, mask 0x005, three passes");
    for (int i = 0; i < NCH; i++) begin gcnt[i] = 0; fcnt[i] = 0; end
    since0 = -1; steps = 0; prevIdx = '0; other = '0; doneSeen = 1'b0;
    startRun(11'h005, 8'd3);
    for (int cyc = 1; cyc <= 200 && !doneSeen; cyc++) begin
      @(negedge clk);
      clearInputs();
      go_ready     = '1;
      fin_valid[0] = 1'b1;
      fin_valid[2] = (since0 >= 5);
      #1;
      if (done_valid) begin
        doneSeen = 1'b1;
        checkOutput("mp_final_idx", pass_idx, 2);
        checkOutput("mp_err", err_timeout, 0);
      end else begin
        if (pass_idx != prevIdx) begin
          checkOutput("mp_idx_step", pass_idx, prevIdx + 8'd1);
          prevIdx = pass_idx;
          steps++;
        end
        gx = go_valid & go_ready;
        fx = fin_valid & fin_ready;
        other |= (go_valid | fin_ready | fx) & ~11'h005;
        for (int i = 0; i < NCH; i++) begin
          gcnt[i] += int'(gx[i]);
          fcnt[i] += int'(fx[i]);
        end
        if (fx[2]) since0 = -1;
        else if (fx[0]) since0 = 0;
        else if (since0 >= 0) since0++;
      end
    end
    checkOutput("mp_done_seen", doneSeen, 1);
    checkOutput("mp_idx_steps", steps, 2);
    checkOutput("mp_go_ch0", gcnt[0], 3);
    checkOutput("mp_go_ch2", gcnt[2], 3);
    checkOutput("mp_fin_ch0", fcnt[0], 3);
    checkOutput("mp_fin_ch2", fcnt[2], 3);
    checkOutput("mp_other_channels", other, 0);
    finishDone();

    $display("[TB] staggered go: channel 0 go late, channel 1 finishes early");
    fin1 = -1; go0 = -1; fin0 = -1; doneAt = -1;
    startRun(11'h003, 8'd1);
    for (int cyc = 1; cyc <= 60 && doneAt < 0; cyc++) begin
      @(negedge clk);
      clearInputs();
      go_ready[1] = 1'b1;
      go_ready[0] = (cyc >= 10);
      fin_valid   = 11'h003;
      #1;
      if (done_valid) begin
        doneAt = cyc;
      end else begin
        gx = go_valid & go_ready;
        fx = fin_valid & fin_ready;
        if (fx[1]) fin1 = cyc;
        if (gx[0]) go0 = cyc;
        if (fx[0]) fin0 = cyc;
      end
    end
    checkOutput("stg_fin1_cycle", fin1, 2);
    checkOutput("stg_go0_cycle", go0, 10);
    checkOutput("stg_fin0_cycle", fin0, 11);
    checkOutput("stg_done_cycle", doneAt, 12);
    finishDone();

    $display("[TB] watchdog: channel 4 never finishes");
    doneAt = -1; errEarly = 1'b0;
    startRun(11'h010, 8'd1);
    for (int cyc = 1; cyc <= 60 && doneAt < 0; cyc++) begin
      @(negedge clk);
      clearInputs();
      go_ready = '1;
      #1;
      if (done_valid) begin
        doneAt = cyc;
        checkOutput("wd_err_at_done", err_timeout, 1);
      end else begin
        errEarly |= err_timeout;
      end
    end
    checkOutput("wd_done_cycle", doneAt, 21);
    checkOutput("wd_err_early", errEarly, 0);
    @(negedge clk);
    clearInputs();
    fin_valid[4] = 1'b1;
    #1;
    checkOutput("wd_late_fin_ready", fin_ready, 0);
    checkOutput("wd_done_hold", done_valid, 1);
    @(negedge clk);
    done_ready   = 1'b1;
    fin_valid[4] = 1'b1;
    #1;
    checkOutput("wd_late_fin_ready2", fin_ready, 0);
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("wd_idle_ready", start_ready, 1);
    checkOutput("wd_err_holds", err_timeout, 1);

    $display("[TB] watchdog boundary: finish on the last allowed cycle");
    doneAt = -1;
    startRun(11'h010, 8'd1);
    for (int cyc = 1; cyc <= 60 && doneAt < 0; cyc++) begin
      @(negedge clk);
      clearInputs();
      go_ready     = '1;
      fin_valid[4] = (cyc == 20);
      #1;
      if (cyc == 1) checkOutput("tie_err_cleared", err_timeout, 0);
      if (done_valid) begin
        doneAt = cyc;
        checkOutput("tie_err", err_timeout, 0);
      end
    end
    checkOutput("tie_done_cycle", doneAt, 21);
    finishDone();

    $display("[TB] reset mid-pass with go partly outstanding");
    startRun(11'h7FF, 8'd1);
    @(negedge clk);
    clearInputs();
    go_ready = 11'h00F;
    #1;
    checkOutput("rm_go_all", go_valid, 11'h7FF);
    @(negedge clk);
    go_ready = '0;
    #1;
    checkOutput("rm_go_partial", go_valid, 11'h7F0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rm_go_valid", go_valid, 0);
    checkOutput("rm_fin_ready", fin_ready, 0);
    checkOutput("rm_done_valid", done_valid, 0);
    checkOutput("rm_busy", busy, 0);
    checkOutput("rm_err", err_timeout, 0);
    checkOutput("rm_pass_idx", pass_idx, 0);
    checkOutput("rm_start_ready", start_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rm_ready_after", start_ready, 1);

    // Fresh two-pass run with everything ready: one bubble cycle between passes.
    expGo   = '{11'h7FF, 11'h000, 11'h7FF, 11'h000, 11'h000};
    expFr   = '{11'h000, 11'h7FF, 11'h000, 11'h7FF, 11'h000};
    expIdx  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
    expDone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    startRun(11'h7FF, 8'd2);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      clearInputs();
      go_ready  = '1;
      fin_valid = '1;
      #1;
      checkOutput($sformatf("fr_c%0d_go", cyc), go_valid, expGo[cyc-1]);
      checkOutput($sformatf("fr_c%0d_fin_ready", cyc), fin_ready, expFr[cyc-1]);
      checkOutput($sformatf("fr_c%0d_done", cyc), done_valid, expDone[cyc-1]);
      if (!expDone[cyc-1]) checkOutput($sformatf("fr_c%0d_idx", cyc), pass_idx, expIdx[cyc-1]);
    end
    checkOutput("fr_err", err_timeout, 0);
    finishDone();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
